// File: rtl/uart_tx_cfg_if.sv
// Bus bundle for the configurable UART transmitter: line configuration,
// queue write port, flow control and status/serial outputs.
interface uart_tx_cfg_if #(
    parameter int FIFO_DEPTH = 32,
    parameter int BAUD_W     = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [BAUD_W-1:0] baud_div_i;
    logic [1:0]        data_bits_i;
    logic [1:0]        parity_i;
    logic              stop2_i;
    logic              we_i;
    logic [7:0]        data_i;
    logic              stall_i;
    logic              full_o;
    logic              empty_o;
    logic [CNT_W-1:0]  count_o;
    logic              busy_o;
    logic              overflow_o;
    logic              tx_o;

    // Host side: drives configuration and writes, observes status and line.
    modport master (
        output baud_div_i, data_bits_i, parity_i, stop2_i, we_i, data_i, stall_i,
        input  full_o, empty_o, count_o, busy_o, overflow_o, tx_o
    );

    // Transmitter side.
    modport slave (
        input  baud_div_i, data_bits_i, parity_i, stop2_i, we_i, data_i, stall_i,
        output full_o, empty_o, count_o, busy_o, overflow_o, tx_o
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: byte queue feeding a frame FSM that emits
// start, 5..8 data bits (LSB first), optional even/odd parity and 1 or 2
// stop bits, one bit per baud tick. FIFO_DEPTH must be a power of two >= 2.
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 32,
    parameter int BAUD_W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    uart_tx_cfg_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Baud timing
    logic [BAUD_W-1:0] r_baud_cnt;
    logic              w_tick;

    // Queue
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;

    // Frame
    state_t            r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic [2:0]        r_last_idx;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_tx;

    // Keep only the configured number of data bits (5 + bits code).
    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] bits);
        logic [7:0] m;
        m = 8'hFF >> (2'd3 - bits);
        return d & m;
    endfunction

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign w_tick      = (r_baud_cnt == bus.baud_div_i);
    assign w_push      = bus.we_i && !r_full;
    assign w_pop       = w_tick && (r_state == S_IDLE) && !r_empty && !bus.stall_i;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Free-running bit-period counter; tick marks the last cycle of each period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.data_i;
        end
    end

    // Queue pointers and registered status; a write while full is dropped even if a pop frees a slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= bus.we_i && r_full;
        end
    end

    // Frame sequencer; every transition and line change happens on a baud tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_bit_idx <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_shift    <= mask_data(r_mem[r_rptr], bus.data_bits_i);
                        r_last_idx <= {1'b1, bus.data_bits_i};
                        r_par_en   <= ^bus.parity_i;
                        r_par_bit  <= parity_bit(mask_data(r_mem[r_rptr], bus.data_bits_i),
                                                 bus.parity_i[1]);
                        r_stop2    <= bus.stop2_i;
                    end
                end
                S_START: begin
                    r_state   <= S_DATA;
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= '0;
                end
                S_DATA: begin
                    if (r_bit_idx == r_last_idx) begin
                        if (r_par_en) begin
                            r_state <= S_PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state <= S_STOP1;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                    end
                end
                S_PARITY: begin
                    r_state <= S_STOP1;
                    r_tx    <= 1'b1;
                end
                S_STOP1: begin
                    r_state <= r_stop2 ? S_STOP2 : S_IDLE;
                    r_tx    <= 1'b1;
                end
                S_STOP2: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full_o     = r_full;
    assign bus.empty_o    = r_empty;
    assign bus.count_o    = r_count;
    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.overflow_o = r_overflow;
    assign bus.tx_o       = r_tx;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: expected line waveforms are built from the frame
// format (start, data LSB first, parity, stops) and compared cycle by cycle.
module tb_uart_tx_cfg;
    localparam int FIFO_DEPTH = 32;
    localparam int BAUD_W     = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) bus ();

    uart_tx_cfg #(.FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         exp_bits[$];
    logic [7:0] model_q[$];
    int         cur_div;

    task automatic do_reset(input int div);
        bus.we_i       = 1'b0;
        bus.data_i     = 8'h00;
        bus.stall_i    = 1'b0;
        bus.baud_div_i = BAUD_W'(div);
        cur_div        = div;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
        bus.data_bits_i = db;
        bus.parity_i    = par;
        bus.stop2_i     = s2;
    endtask

    // Expected serial bits of one frame, derived from the line format.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] par, input logic s2);
        int n;
        bit p;
        n = 5 + int'(db);
        p = 1'b0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 2'b01) exp_bits.push_back(p);
        else if (par == 2'b10) exp_bits.push_back(!p);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
    endfunction

    // One-cycle write; when chk is set the queue status is compared to the model.
    task automatic write_byte(input logic [7:0] b, input bit chk);
        bit drop;
        int exp_cnt;
        drop        = (model_q.size() >= FIFO_DEPTH);
        bus.we_i    = 1'b1;
        bus.data_i  = b;
        @(negedge clk);
        bus.we_i    = 1'b0;
        if (!drop) model_q.push_back(b);
        if (chk) begin
            exp_cnt = model_q.size();
            n_checks++;
            if (bus.count_o !== CNT_W'(exp_cnt) || bus.full_o !== (exp_cnt == FIFO_DEPTH)
                || bus.empty_o !== 1'b0) begin
                n_fail++;
                $display("FAIL write_status: count_o=%0d full_o=%b empty_o=%b required count_o=%0d full_o=%b empty_o=0",
                         bus.count_o, bus.full_o, bus.empty_o, exp_cnt, (exp_cnt == FIFO_DEPTH));
            end
            n_checks++;
            if (bus.overflow_o !== drop) begin
                n_fail++;
                $display("FAIL write_overflow: overflow_o=%b required %b", bus.overflow_o, drop);
            end
        end
    endtask

    // Waits for the start bit, then compares tx_o/busy_o every cycle of the frame in exp_bits.
    task automatic check_frame(input string name, input bit scramble);
        int waited;
        int bad;
        int len;
        logic got_tx;
        logic got_busy;
        waited = 0;
        bad    = -1;
        got_tx = 1'b0;
        got_busy = 1'b0;
        while (bus.tx_o !== 1'b0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.tx_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_timeout: tx_o=%b required 0", name, bus.tx_o);
            return;
        end
        len = exp_bits.size() * (cur_div + 1);
        for (int i = 0; i < len; i++) begin
            if (bad < 0 && (bus.tx_o !== exp_bits[i / (cur_div + 1)] || bus.busy_o !== 1'b1)) begin
                bad      = i;
                got_tx   = bus.tx_o;
                got_busy = bus.busy_o;
            end
            if (scramble && i == len / 2) begin
                bus.data_bits_i = 2'($urandom);
                bus.parity_i    = 2'($urandom);
                bus.stop2_i     = 1'($urandom);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s waveform cycle %0d: tx_o=%b busy_o=%b required tx_o=%b busy_o=1",
                     name, bad, got_tx, got_busy, exp_bits[bad / (cur_div + 1)]);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.tx_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_end: busy_o=%b tx_o=%b required busy_o=0 tx_o=1",
                     name, bus.busy_o, bus.tx_o);
        end
    endtask

    task automatic test_reset();
        set_cfg(2'b11, 2'b00, 1'b0);
        do_reset(3);
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx: tx_o=%b required 1", bus.tx_o); end
        n_checks++;
        if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: empty_o=%b required 1", bus.empty_o); end
        n_checks++;
        if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: full_o=%b required 0", bus.full_o); end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy_o=%b required 0", bus.busy_o); end
        n_checks++;
        if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: overflow_o=%b required 0", bus.overflow_o); end
        n_checks++;
        if (bus.count_o !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: count_o=%0d required 0", bus.count_o); end
    endtask

    task automatic test_8n1();
        bit ref_bits[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        do_reset(3);
        set_cfg(2'b11, 2'b00, 1'b0);
        write_byte(8'h55, 1'b1);
        exp_bits.delete();
        foreach (ref_bits[i]) exp_bits.push_back(ref_bits[i]);
        void'(model_q.pop_front());
        check_frame("8n1_55", 1'b0);
    endtask

    task automatic test_7e1();
        bit ref_bits[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        do_reset(3);
        set_cfg(2'b10, 2'b01, 1'b0);
        write_byte(8'h41, 1'b1);
        exp_bits.delete();
        foreach (ref_bits[i]) exp_bits.push_back(ref_bits[i]);
        void'(model_q.pop_front());
        check_frame("7e1_41", 1'b0);
    endtask

    task automatic test_8o2();
        bit ref_bits[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        do_reset(2);
        set_cfg(2'b11, 2'b10, 1'b1);
        write_byte(8'hFF, 1'b1);
        exp_bits.delete();
        foreach (ref_bits[i]) exp_bits.push_back(ref_bits[i]);
        void'(model_q.pop_front());
        check_frame("8o2_ff", 1'b0);
    endtask

    task automatic test_random_frames();
        logic [1:0] db, par;
        logic       s2;
        logic [7:0] b;
        do_reset($urandom_range(0, 4));
        for (int k = 0; k < 12; k++) begin
            db  = 2'($urandom);
            par = 2'($urandom);
            s2  = 1'($urandom);
            b   = 8'($urandom);
            set_cfg(db, par, s2);
            write_byte(b, 1'b1);
            build_frame(model_q.pop_front(), db, par, s2);
            check_frame("random_frame", 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] db, par;
        logic       s2;
        do_reset($urandom_range(0, 3));
        db  = 2'($urandom);
        par = 2'($urandom);
        s2  = 1'($urandom);
        set_cfg(db, par, s2);
        bus.stall_i = 1'b1;
        for (int k = 0; k < 4; k++) write_byte(8'($urandom), 1'b1);
        bus.stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            build_frame(model_q.pop_front(), db, par, s2);
            check_frame("back_to_back", 1'b0);
        end
    endtask

    task automatic test_queue_full();
        logic [1:0] cdb[FIFO_DEPTH];
        logic [1:0] cpar[FIFO_DEPTH];
        logic       cs2[FIFO_DEPTH];
        do_reset(1);
        bus.stall_i = 1'b1;
        for (int k = 0; k < FIFO_DEPTH + 1; k++) write_byte(8'($urandom), 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.overflow_o !== 1'b0 || bus.count_o !== CNT_W'(FIFO_DEPTH) || bus.full_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: overflow_o=%b count_o=%0d full_o=%b required 0/%0d/1",
                     bus.overflow_o, bus.count_o, bus.full_o, FIFO_DEPTH);
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            cdb[k]  = 2'($urandom);
            cpar[k] = 2'($urandom);
            cs2[k]  = 1'($urandom);
        end
        set_cfg(cdb[0], cpar[0], cs2[0]);
        bus.stall_i = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            build_frame(model_q.pop_front(), cdb[k], cpar[k], cs2[k]);
            check_frame("queued_frame", 1'b1);
            if (k + 1 < FIFO_DEPTH) set_cfg(cdb[k+1], cpar[k+1], cs2[k+1]);
        end
        n_checks++;
        if (bus.empty_o !== 1'b1 || bus.count_o !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL drained: empty_o=%b count_o=%0d required 1/0", bus.empty_o, bus.count_o);
        end
    endtask

    task automatic test_full_write_pop();
        do_reset(0);
        set_cfg(2'b11, 2'b00, 1'b0);
        bus.stall_i = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) write_byte(8'($urandom), 1'b0);
        // Tick every cycle, so releasing stall pops on the same edge as this write.
        bus.stall_i = 1'b0;
        bus.we_i    = 1'b1;
        bus.data_i  = 8'hA5;
        @(negedge clk);
        bus.we_i = 1'b0;
        n_checks++;
        if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL wp_overflow: overflow_o=%b required 1", bus.overflow_o); end
        n_checks++;
        if (bus.count_o !== CNT_W'(FIFO_DEPTH - 1)) begin
            n_fail++; $display("FAIL wp_count: count_o=%0d required %0d", bus.count_o, FIFO_DEPTH - 1);
        end
        n_checks++;
        if (bus.full_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL wp_flags: full_o=%b busy_o=%b required 0/1", bus.full_o, bus.busy_o);
        end
        build_frame(model_q.pop_front(), 2'b11, 2'b00, 1'b0);
        check_frame("wp_first_frame", 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        bit quiet;
        do_reset(3);
        set_cfg(2'b11, 2'b00, 1'b0);
        bus.stall_i = 1'b1;
        write_byte(8'hF7, 1'b0);
        write_byte(8'h00, 1'b0);
        bus.stall_i = 1'b0;
        waited = 0;
        while (bus.tx_o !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        // Start bit is 4 cycles, then data bits 0..2; cycle 17 lies inside data bit 3.
        repeat (17) @(negedge clk);
        n_checks++;
        if (bus.tx_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_bit3: tx_o=%b busy_o=%b required 0/1", bus.tx_o, bus.busy_o);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.tx_o !== 1'b1 || bus.count_o !== CNT_W'(0) || bus.busy_o !== 1'b0 || bus.empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: tx_o=%b count_o=%0d busy_o=%b empty_o=%b required 1/0/0/1",
                     bus.tx_o, bus.count_o, bus.busy_o, bus.empty_o);
        end
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL post_reset_idle: line activity %b required none", !quiet); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_8o2();
        test_random_frames();
        test_back_to_back();
        test_queue_full();
        test_full_write_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
